// File: rtl/irq_controller.sv
// irq_controller: aggregates NUM_SRC interrupt lines into one prioritized
// request plus source ID. Each source is synchronized and captured either as
// a level or as a rising edge. An enable mask is applied, and edge captures are
// acknowledged by write-1-to-clear. Registers sit on the 32-bit CPU I/O bus
// with a registered read path.
//
// Register map (addrBus[3:2]):
//   0 PENDING  R / W1C (edge-mode bits only)
//   1 ENABLE   RW, byte-lane writes
//   2 EDGE     RW, 1 = rising-edge capture, 0 = level
//   3 STATUS   R, {irqOut, 26'h0, irqId}
module irq_controller #(
    parameter int NUM_SRC = 8,
    parameter bit SYNC    = 1'b1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_SRC-1:0] irqIn,
    input  logic [31:0]        addrBus,
    input  logic [31:0]        dataInBus,
    input  logic [3:0]         weBus,
    input  logic               en,
    output logic [31:0]        dataOutBus,
    output logic               irqOut,
    output logic [4:0]         irqId
);

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_ENABLE  = 2'd1;
    localparam logic [1:0] ADDR_EDGE    = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    logic [NUM_SRC-1:0] sync_in;
    logic [NUM_SRC-1:0] prev;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] pending_nxt;
    logic [NUM_SRC-1:0] enable_r;
    logic [NUM_SRC-1:0] enable_nxt;
    logic [NUM_SRC-1:0] edge_r;
    logic [NUM_SRC-1:0] edge_nxt;
    logic [NUM_SRC-1:0] lane_we;
    logic [NUM_SRC-1:0] masked;
    logic [4:0]         id_nxt;
    logic [31:0]        rd_nxt;
    logic               sel_pend;
    logic               sel_en;
    logic               sel_edge;
    logic               unused_bits;

    // Only addrBus[3:2] is decoded; wide buses are partly unused for small NUM_SRC.
    assign unused_bits = ^{addrBus[31:4], addrBus[1:0], dataInBus, weBus};

    generate
        if (SYNC) begin : g_sync
            logic [NUM_SRC-1:0] s1;
            logic [NUM_SRC-1:0] s2;

            // Two-flop synchronizer for asynchronous device interrupt lines.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    s1 <= '0;
                    s2 <= '0;
                end else begin
                    s1 <= irqIn;
                    s2 <= s1;
                end
            end

            assign sync_in = s2;
        end else begin : g_nosync
            assign sync_in = irqIn;
        end
    endgenerate

    assign rise     = sync_in & ~prev;
    assign masked   = pending & enable_r;
    assign sel_pend = en && (addrBus[3:2] == ADDR_PENDING);
    assign sel_en   = en && (addrBus[3:2] == ADDR_ENABLE);
    assign sel_edge = en && (addrBus[3:2] == ADDR_EDGE);

    // Map each source bit to the byte-lane write enable that covers it.
    always_comb begin
        lane_we = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            lane_we[i] = weBus[i / 8];
        end
    end

    // Next-state for pending/enable/edge; a rise beats a same-cycle W1C so no interrupt is lost.
    always_comb begin
        pending_nxt = pending;
        enable_nxt  = enable_r;
        edge_nxt    = edge_r;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!edge_r[i]) begin
                pending_nxt[i] = sync_in[i];
            end else if (rise[i]) begin
                pending_nxt[i] = 1'b1;
            end else if (sel_pend && lane_we[i] && dataInBus[i]) begin
                pending_nxt[i] = 1'b0;
            end
            if (sel_en && lane_we[i]) begin
                enable_nxt[i] = dataInBus[i];
            end
            if (sel_edge && lane_we[i]) begin
                edge_nxt[i] = dataInBus[i];
            end
        end
    end

    // Priority encoder: scanning downward leaves the lowest set index.
    always_comb begin
        id_nxt = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (masked[i]) begin
                id_nxt = 5'(i);
            end
        end
    end

    // Read mux from pre-edge state; unimplemented upper bits read 0.
    always_comb begin
        rd_nxt = '0;
        case (addrBus[3:2])
            ADDR_PENDING: rd_nxt[NUM_SRC-1:0] = pending;
            ADDR_ENABLE:  rd_nxt[NUM_SRC-1:0] = enable_r;
            ADDR_EDGE:    rd_nxt[NUM_SRC-1:0] = edge_r;
            ADDR_STATUS:  rd_nxt = {irqOut, 26'h0, irqId};
            default:      rd_nxt = '0;
        endcase
    end

    // Capture state; prev runs every cycle so a mode change never fakes an edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev       <= '0;
            pending    <= '0;
            enable_r   <= '0;
            edge_r     <= '0;
            dataOutBus <= '0;
            irqOut     <= 1'b0;
            irqId      <= '0;
        end else begin
            prev       <= sync_in;
            pending    <= pending_nxt;
            enable_r   <= enable_nxt;
            edge_r     <= edge_nxt;
            dataOutBus <= rd_nxt;
            irqOut     <= |masked;
            irqId      <= id_nxt;
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller (NUM_SRC=8, SYNC=1) with hand-computed expectations.
module tb_irq_controller;

    logic        clk;
    logic        rstn;
    logic [7:0]  irqIn;
    logic [31:0] addrBus;
    logic [31:0] dataInBus;
    logic [3:0]  weBus;
    logic        en;
    logic [31:0] dataOutBus;
    logic        irqOut;
    logic [4:0]  irqId;

    int checks;
    int errors;

    irq_controller #(.NUM_SRC(8), .SYNC(1'b1)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .irqIn      (irqIn),
        .addrBus    (addrBus),
        .dataInBus  (dataInBus),
        .weBus      (weBus),
        .en         (en),
        .dataOutBus (dataOutBus),
        .irqOut     (irqOut),
        .irqId      (irqId)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [1:0] reg_sel, input logic [31:0] data, input logic [3:0] we);
        addrBus   = {28'h0, reg_sel, 2'b00};
        dataInBus = data;
        weBus     = we;
        en        = 1'b1;
        tick();
        en        = 1'b0;
        weBus     = 4'h0;
        dataInBus = 32'h0;
    endtask

    task automatic bus_read(input logic [1:0] reg_sel, output logic [31:0] data);
        addrBus = {28'h0, reg_sel, 2'b00};
        tick();
        data = dataOutBus;
    endtask

    logic [31:0] rd;

    initial begin
        checks    = 0;
        errors    = 0;
        rstn      = 1'b0;
        irqIn     = 8'h00;
        addrBus   = 32'h0;
        dataInBus = 32'h0;
        weBus     = 4'h0;
        en        = 1'b0;

        ticks(2);
        check("rst_irqout", {31'h0, irqOut}, 32'h0);
        check("rst_irqid", {27'h0, irqId}, 32'h0);
        check("rst_dout", dataOutBus, 32'h0);
        rstn = 1'b1;
        tick();

        // Edge capture of a 1-cycle pulse on source 1
        bus_write(2'd2, 32'h02, 4'hF);
        bus_write(2'd1, 32'h02, 4'hF);
        irqIn = 8'h02;
        tick();                       // N: s1
        irqIn = 8'h00;
        tick();                       // N+1: s2
        tick();                       // N+2: pending
        check("edge_irqout_n2", {31'h0, irqOut}, 32'h0);
        tick();                       // N+3
        check("edge_irqout_n3", {31'h0, irqOut}, 32'h1);
        check("edge_irqid", {27'h0, irqId}, 32'h1);
        bus_read(2'd0, rd);
        check("edge_pending", rd, 32'h02);
        bus_write(2'd0, 32'h02, 4'hF);
        check("w1c_irqout_m", {31'h0, irqOut}, 32'h1);
        tick();
        check("w1c_irqout_m1", {31'h0, irqOut}, 32'h0);
        bus_read(2'd0, rd);
        check("w1c_pending", rd, 32'h00);

        // Priority among level sources
        bus_write(2'd2, 32'h00, 4'hF);
        bus_write(2'd1, 32'hFF, 4'hF);
        irqIn = 8'h24;
        ticks(4);
        check("prio_irqout", {31'h0, irqOut}, 32'h1);
        check("prio_id_2", {27'h0, irqId}, 32'h2);
        irqIn = 8'h20;
        ticks(3);
        check("prio_id_hold", {27'h0, irqId}, 32'h2);
        tick();
        check("prio_id_5", {27'h0, irqId}, 32'h5);

        // Masking
        irqIn = 8'h08;
        bus_write(2'd1, 32'h00, 4'hF);
        ticks(4);
        check("mask_irqout", {31'h0, irqOut}, 32'h0);
        bus_read(2'd0, rd);
        check("mask_pending", rd, 32'h08);
        bus_write(2'd1, 32'h08, 4'hF);
        check("mask_irqout_m", {31'h0, irqOut}, 32'h0);
        tick();
        check("mask_irqout_m1", {31'h0, irqOut}, 32'h1);
        check("mask_irqid", {27'h0, irqId}, 32'h3);
        bus_write(2'd1, 32'h00, 4'hE);   // lane 0 not enabled: ignored
        tick();
        check("lane_irqout", {31'h0, irqOut}, 32'h1);
        bus_read(2'd1, rd);
        check("lane_enable", rd, 32'h08);

        // Collision: rise of edge source 0 with W1C of bit 0
        irqIn = 8'h00;
        bus_write(2'd2, 32'h01, 4'hF);
        bus_write(2'd1, 32'h01, 4'hF);
        ticks(3);
        irqIn = 8'h01;
        tick();                       // N: s1
        tick();                       // N+1: s2, rise visible
        bus_write(2'd0, 32'h01, 4'hF); // N+2: rise and W1C together
        bus_read(2'd0, rd);
        check("collide_pending", rd, 32'h01);
        bus_write(2'd0, 32'h01, 4'hF); // held high, no new rise: clears
        bus_read(2'd0, rd);
        check("held_w1c_pending", rd, 32'h00);

        // Level W1C ignored; STATUS format
        irqIn = 8'h10;
        bus_write(2'd2, 32'h00, 4'hF);
        bus_write(2'd1, 32'h10, 4'hF);
        ticks(4);
        bus_write(2'd0, 32'h10, 4'hF);
        bus_read(2'd0, rd);
        check("lvl_w1c_pending", rd, 32'h10);
        bus_read(2'd3, rd);
        check("status", rd, 32'h80000004);
        bus_write(2'd2, 32'hFFFFFFFF, 4'hF);
        bus_read(2'd2, rd);
        check("edge_upper_zero", rd, 32'h000000FF);
        tick();
        bus_read(2'd0, rd);
        check("lvl2edge_keep", rd, 32'h10);
        bus_write(2'd2, 32'h00, 4'hF);

        // Reset mid-operation
        irqIn = 8'hFF;
        bus_write(2'd1, 32'hFF, 4'hF);
        ticks(4);
        bus_read(2'd3, rd);
        check("pre_rst_status", rd, 32'h80000000);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_irqout", {31'h0, irqOut}, 32'h0);
        check("arst_irqid", {27'h0, irqId}, 32'h0);
        check("arst_dout", dataOutBus, 32'h0);
        irqIn = 8'h00;
        tick();
        rstn = 1'b1;
        bus_read(2'd0, rd);
        check("post_rst_pending", rd, 32'h0);
        bus_read(2'd1, rd);
        check("post_rst_enable", rd, 32'h0);
        bus_read(2'd2, rd);
        check("post_rst_edge", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
